// File: rtl/wb_scoreboard_arbiter_if.sv
// Bundles the decode-issue port, the two writeback request ports and the
// register-file write port shared between the pipeline and the scoreboard.
interface wb_scoreboard_arbiter_if #(
   parameter int ARCH_LEN     = 32,
   parameter int REG_FILE_LEN = 32
);
   localparam int IDX_W = $clog2(REG_FILE_LEN);

   logic             issue_valid;
   logic [IDX_W-1:0] issue_dst;
   logic [IDX_W-1:0] issue_src_1;
   logic [IDX_W-1:0] issue_src_2;
   logic             issue_stall;

   logic                alu_wb_valid;
   logic [IDX_W-1:0]    alu_wb_dst;
   logic [ARCH_LEN-1:0] alu_wb_data;
   logic                alu_wb_ready;

   logic                lsu_wb_valid;
   logic [IDX_W-1:0]    lsu_wb_dst;
   logic [ARCH_LEN-1:0] lsu_wb_data;
   logic                lsu_wb_ready;

   logic [IDX_W-1:0]    dst_reg;
   logic [ARCH_LEN-1:0] dst_reg_data;
   logic                reg_write_enable;

   modport master (
      output issue_valid, issue_dst, issue_src_1, issue_src_2,
      output alu_wb_valid, alu_wb_dst, alu_wb_data,
      output lsu_wb_valid, lsu_wb_dst, lsu_wb_data,
      input  issue_stall, alu_wb_ready, lsu_wb_ready,
      input  dst_reg, dst_reg_data, reg_write_enable
   );

   modport slave (
      input  issue_valid, issue_dst, issue_src_1, issue_src_2,
      input  alu_wb_valid, alu_wb_dst, alu_wb_data,
      input  lsu_wb_valid, lsu_wb_dst, lsu_wb_data,
      output issue_stall, alu_wb_ready, lsu_wb_ready,
      output dst_reg, dst_reg_data, reg_write_enable
   );
endinterface

// File: rtl/wb_scoreboard_arbiter.sv
// Register scoreboard with round-robin ALU/LSU writeback arbitration.
// Issue hazards are checked against registered busy bits only (no bypass).
module wb_scoreboard_arbiter #(
   parameter int ARCH_LEN     = 32,
   parameter int REG_FILE_LEN = 32,
   parameter int IDX_W        = $clog2(REG_FILE_LEN)
) (
   input  logic                      clk,
   input  logic                      rst,
   wb_scoreboard_arbiter_if.slave    bus,
   input  logic                      flush,
   output logic [IDX_W:0]            pending_count,
   output logic                      wb_err
);
   localparam logic GRANT_ALU = 1'b0;
   localparam logic GRANT_LSU = 1'b1;

   logic [REG_FILE_LEN-1:0] busy_q, busy_d;
   logic                    last_grant_q, last_grant_d;
   logic [IDX_W:0]          pending_count_q, pending_count_d;
   logic                    wb_err_q, wb_err_d;

   logic                    issue_stall;
   logic                    issue_accept;
   logic                    alu_win, lsu_win;
   logic [IDX_W-1:0]        win_dst;
   logic [ARCH_LEN-1:0]     win_data;
   logic                    write_en;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q          <= '0;
         last_grant_q    <= GRANT_LSU;
         pending_count_q <= '0;
         wb_err_q        <= 1'b0;
      end else begin
         busy_q          <= busy_d;
         last_grant_q    <= last_grant_d;
         pending_count_q <= pending_count_d;
         wb_err_q        <= wb_err_d;
      end
   end

   // Hazard check and round-robin grant; ALU wins unless it was granted last.
   always_comb begin
      issue_stall  = bus.issue_valid &&
                     (busy_q[bus.issue_src_1] || busy_q[bus.issue_src_2] ||
                      busy_q[bus.issue_dst]);
      issue_accept = bus.issue_valid && !issue_stall;

      alu_win = bus.alu_wb_valid && (!bus.lsu_wb_valid || (last_grant_q == GRANT_LSU));
      lsu_win = bus.lsu_wb_valid && !alu_win;

      win_dst  = '0;
      win_data = '0;
      if (alu_win) begin
         win_dst  = bus.alu_wb_dst;
         win_data = bus.alu_wb_data;
      end else if (lsu_win) begin
         win_dst  = bus.lsu_wb_dst;
         win_data = bus.lsu_wb_data;
      end
      write_en = (alu_win || lsu_win) && (win_dst != '0);
   end

   // Clear before set so an issue reclaiming a just-retired index stays busy.
   always_comb begin
      busy_d       = busy_q;
      last_grant_d = last_grant_q;
      wb_err_d     = wb_err_q;

      if (alu_win) last_grant_d = GRANT_ALU;
      if (lsu_win) last_grant_d = GRANT_LSU;

      if (write_en) begin
         if (!busy_q[win_dst]) wb_err_d = 1'b1;
         busy_d[win_dst] = 1'b0;
      end
      if (issue_accept && (bus.issue_dst != '0)) busy_d[bus.issue_dst] = 1'b1;
      if (flush) busy_d = '0;
      busy_d[0] = 1'b0;

      pending_count_d = '0;
      for (int i = 0; i < REG_FILE_LEN; i++) begin
         pending_count_d = pending_count_d + {{IDX_W{1'b0}}, busy_d[i]};
      end
   end

   always_comb begin
      bus.issue_stall      = issue_stall;
      bus.alu_wb_ready     = alu_win;
      bus.lsu_wb_ready     = lsu_win;
      bus.dst_reg          = win_dst;
      bus.dst_reg_data     = win_data;
      bus.reg_write_enable = write_en;
      pending_count        = pending_count_q;
      wb_err               = wb_err_q;
   end
endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// Table-driven bench for wb_scoreboard_arbiter: same-cycle outputs are checked
// directly, registered results go through an expected-value queue.
module tb_wb_scoreboard_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic flush;
   logic [5:0] pending_count;
   logic wb_err;

   wb_scoreboard_arbiter_if #(.ARCH_LEN(32), .REG_FILE_LEN(32)) bus ();

   wb_scoreboard_arbiter #(.ARCH_LEN(32), .REG_FILE_LEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .flush         (flush),
      .pending_count (pending_count),
      .wb_err        (wb_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [4:0]  id, s1, s2;
      logic        av;
      logic [4:0]  ad;
      logic [31:0] adata;
      logic        lv;
      logic [4:0]  ld;
      logic [31:0] ldata;
      logic        fl;
      logic        e_stall, e_ardy, e_lrdy, e_we;
      logic [4:0]  e_dst;
      logic [31:0] e_data;
      logic [5:0]  e_pend;
      logic        e_err;
   } vec_t;

   typedef struct {
      logic [5:0] pend;
      logic       err;
   } reg_exp_t;

   reg_exp_t exp_q[$];
   vec_t     tbl[16];
   int       errors = 0;
   int       checks = 0;

   function automatic vec_t mk(int iv, int id, int s1, int s2,
                               int av, int ad, logic [31:0] adata,
                               int lv, int ld, logic [31:0] ldata, int fl,
                               int st, int ar, int lr, int we, int edst,
                               logic [31:0] edata, int pend, int err);
      vec_t v;
      v.iv = 1'(iv);  v.id = 5'(id);  v.s1 = 5'(s1);  v.s2 = 5'(s2);
      v.av = 1'(av);  v.ad = 5'(ad);  v.adata = adata;
      v.lv = 1'(lv);  v.ld = 5'(ld);  v.ldata = ldata;
      v.fl = 1'(fl);
      v.e_stall = 1'(st); v.e_ardy = 1'(ar); v.e_lrdy = 1'(lr); v.e_we = 1'(we);
      v.e_dst = 5'(edst); v.e_data = edata;
      v.e_pend = 6'(pend); v.e_err = 1'(err);
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic drive_idle();
      bus.issue_valid  = 1'b0; bus.issue_dst  = '0;
      bus.issue_src_1  = '0;   bus.issue_src_2 = '0;
      bus.alu_wb_valid = 1'b0; bus.alu_wb_dst = '0; bus.alu_wb_data = '0;
      bus.lsu_wb_valid = 1'b0; bus.lsu_wb_dst = '0; bus.lsu_wb_data = '0;
      flush = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string nm);
      reg_exp_t e;
      @(negedge clk);
      bus.issue_valid  = v.iv; bus.issue_dst  = v.id;
      bus.issue_src_1  = v.s1; bus.issue_src_2 = v.s2;
      bus.alu_wb_valid = v.av; bus.alu_wb_dst = v.ad; bus.alu_wb_data = v.adata;
      bus.lsu_wb_valid = v.lv; bus.lsu_wb_dst = v.ld; bus.lsu_wb_data = v.ldata;
      flush = v.fl;
      #2;
      check({nm, " stall"}, 64'(bus.issue_stall),      64'(v.e_stall));
      check({nm, " alu_rdy"}, 64'(bus.alu_wb_ready),   64'(v.e_ardy));
      check({nm, " lsu_rdy"}, 64'(bus.lsu_wb_ready),   64'(v.e_lrdy));
      check({nm, " we"}, 64'(bus.reg_write_enable),    64'(v.e_we));
      check({nm, " dst_reg"}, 64'(bus.dst_reg),        64'(v.e_dst));
      check({nm, " dst_data"}, 64'(bus.dst_reg_data),  64'(v.e_data));
      exp_q.push_back('{pend: v.e_pend, err: v.e_err});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({nm, " pending"}, 64'(pending_count), 64'(e.pend));
      check({nm, " wb_err"}, 64'(wb_err), 64'(e.err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive_idle();
      rst = 1'b0;
      #1;
      check("rst pending", 64'(pending_count), 64'd0);
      check("rst wb_err", 64'(wb_err), 64'd0);
      check("rst stall", 64'(bus.issue_stall), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      drive_idle();

      //        iv id s1 s2 av ad adata         lv ld ldata  fl st ar lr we dst data          pend err
      tbl[0]  = mk(1, 5, 0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            1, 0);
      tbl[1]  = mk(1, 6, 5, 0, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 0, 0, 0,            1, 0);
      tbl[2]  = mk(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 0, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0);
      tbl[3]  = mk(1, 6, 5, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            1, 0);
      tbl[4]  = mk(1, 3, 0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            2, 0);
      tbl[5]  = mk(1, 4, 0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            3, 0);
      tbl[6]  = mk(0, 0, 0, 0, 1, 3, 32'h33,       1, 4, 32'h44, 0, 0, 0, 1, 1, 4, 32'h44,      2, 0);
      tbl[7]  = mk(0, 0, 0, 0, 1, 3, 32'h33,       1, 4, 32'h44, 0, 0, 1, 0, 1, 3, 32'h33,      1, 0);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            1, 0);
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0,            1, 0, 32'h99, 0, 0, 0, 1, 0, 0, 32'h99,      1, 0);
      tbl[10] = mk(1, 7, 0, 6, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 0, 0, 0,            1, 0);
      tbl[11] = mk(1, 6, 0, 0, 0, 0, 0,            0, 0, 0,     0, 1, 0, 0, 0, 0, 0,            1, 0);
      tbl[12] = mk(1, 8, 6, 0, 1, 6, 32'h66,       0, 0, 0,     0, 1, 1, 0, 1, 6, 32'h66,       0, 0);
      tbl[13] = mk(1, 8, 6, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            1, 0);
      tbl[14] = mk(1, 9, 0, 0, 0, 0, 0,            1, 8, 32'h88, 1, 0, 0, 1, 1, 8, 32'h88,      0, 0);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            0, 0);

      do_reset();
      for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      // Contention straight after reset: A, L, A, L; late writes hit idle regs.
      do_reset();
      apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rr iss3");
      apply(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "rr iss4");
      apply(mk(0, 0, 0, 0, 1, 3, 32'hA3, 1, 4, 32'hB4, 0, 0, 1, 0, 1, 3, 32'hA3, 1, 0), "rr c1");
      apply(mk(0, 0, 0, 0, 1, 3, 32'hA3, 1, 4, 32'hB4, 0, 0, 0, 1, 1, 4, 32'hB4, 0, 0), "rr c2");
      apply(mk(0, 0, 0, 0, 1, 3, 32'hA3, 1, 4, 32'hB4, 0, 0, 1, 0, 1, 3, 32'hA3, 0, 1), "rr c3");
      apply(mk(0, 0, 0, 0, 1, 3, 32'hA3, 1, 4, 32'hB4, 0, 0, 0, 1, 1, 4, 32'hB4, 0, 1), "rr c4");

      // Sticky error, then set-wins-over-clear on the same index.
      do_reset();
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 1, 1, 7, 32'h77, 0, 1), "err lsu7");
      for (int i = 0; i < 10; i++)
         apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), $sformatf("err idle%0d", i));
      apply(mk(1, 10, 0, 0, 1, 10, 32'hA0, 0, 0, 0, 0, 0, 1, 0, 1, 10, 32'hA0, 1, 1), "set wins");
      apply(mk(1, 11, 10, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1), "set held");

      // Fill every register, then flush over an issue.
      do_reset();
      for (int i = 1; i < 32; i++)
         apply(mk(1, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i, 0), $sformatf("fill%0d", i));
      apply(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "flush");
      apply(mk(1, 9, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "post flush");

      // Reset in the middle of activity.
      do_reset();
      apply(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mid iss1");
      apply(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0), "mid iss2");
      apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0), "mid iss3");
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.issue_src_1 = 5'd1; bus.issue_dst = 5'd12;
      #2;
      check("mid pre stall", 64'(bus.issue_stall), 64'd1);
      rst = 1'b0;
      #1;
      check("mid rst pending", 64'(pending_count), 64'd0);
      check("mid rst stall", 64'(bus.issue_stall), 64'd0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      rst = 1'b1;
      apply(mk(0, 0, 0, 0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 1, 0, 1, 1, 32'h11, 0, 1), "mid first rr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
